// File: rtl/vram_arbiter.sv
// Shares the single-port display RAM between scanout fetch (fixed priority) and the CPU bus.
// A saturating wait counter forces a CPU slot after MAX_WAIT lost cycles; read data is routed to the slot owner.
module vram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                    clk,
  input  logic                    reset_i,

  input  logic                    disp_req_i,
  input  logic [ADDR_WIDTH-1:0]   disp_addr_i,
  output logic                    disp_gnt_o,
  output logic                    disp_rvalid_o,
  output logic [DATA_WIDTH-1:0]   disp_rdata_o,

  input  logic                    cpu_req_i,
  input  logic                    cpu_we_i,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cpu_wstrb_i,
  output logic                    cpu_gnt_o,
  output logic                    cpu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   cpu_rdata_o,

  output logic                    mem_en_o,
  output logic [DATA_WIDTH/8-1:0] mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("vram_arbiter: MAX_WAIT must be in 1..15");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $error("vram_arbiter: DATA_WIDTH must be a multiple of 8");
  end

  logic [3:0] wait_cnt;
  logic       disp_pend;
  logic       cpu_pend;
  logic       force_cpu;
  logic       cpu_gnt;
  logic       disp_gnt;

  // Grants are gated by reset so every output is quiet while reset is held.
  always_comb begin
    force_cpu = (wait_cnt == WAIT_LIMIT);
    cpu_gnt   = reset_i & cpu_req_i & (~disp_req_i | force_cpu);
    disp_gnt  = reset_i & disp_req_i & ~cpu_gnt;
  end

  always_comb begin
    disp_gnt_o = disp_gnt;
    cpu_gnt_o  = cpu_gnt;
  end

  always_comb begin
    mem_en_o    = disp_gnt | cpu_gnt;
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (cpu_gnt) begin
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
      mem_we_o    = cpu_we_i ? cpu_wstrb_i : '0;
    end else if (disp_gnt) begin
      mem_addr_o  = disp_addr_i;
    end
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      wait_cnt  <= '0;
      disp_pend <= 1'b0;
      cpu_pend  <= 1'b0;
    end else begin
      disp_pend <= disp_gnt;
      cpu_pend  <= cpu_gnt;
      if (cpu_req_i && !cpu_gnt) begin
        if (wait_cnt != WAIT_LIMIT) begin
          wait_cnt <= wait_cnt + 4'd1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    disp_rvalid_o = disp_pend;
    cpu_rvalid_o  = cpu_pend;
    disp_rdata_o  = disp_pend ? mem_rdata_i : '0;
    cpu_rdata_o   = cpu_pend  ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized and directed bench for vram_arbiter against a cycle-level behavioural model.
// The bench also plays the RAM (read-first, one-cycle read latency).
module tb_vram_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset_i = 1'b0;
  logic          disp_req_i = 1'b0;
  logic [AW-1:0] disp_addr_i = '0;
  logic          disp_gnt_o, disp_rvalid_o;
  logic [DW-1:0] disp_rdata_o;
  logic          cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [AW-1:0] cpu_addr_i = '0;
  logic [DW-1:0] cpu_wdata_i = '0;
  logic [SW-1:0] cpu_wstrb_i = '0;
  logic          cpu_gnt_o, cpu_rvalid_o;
  logic [DW-1:0] cpu_rdata_o;
  logic          mem_en_o;
  logic [SW-1:0] mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;

  vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset_i(reset_i),
    .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i), .disp_gnt_o(disp_gnt_o),
    .disp_rvalid_o(disp_rvalid_o), .disp_rdata_o(disp_rdata_o),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_wstrb_i(cpu_wstrb_i), .cpu_gnt_o(cpu_gnt_o),
    .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pattern(input int unsigned i);
    logic [DW-1:0] v;
    v = (32'h9E3779B9 * i) ^ (i << 16);
    if (i == 5) v = 32'hDEADBEEF;
    return v;
  endfunction

  // Environment RAM
  logic          ram_init = 1'b0;
  logic [DW-1:0] ram [1 << AW];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= pattern(i);
    end else if (mem_en_o) begin
      mem_rdata_i <= ram[mem_addr_o];
      for (int b = 0; b < SW; b++)
        if (mem_we_o[b]) ram[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [1 << AW];
  int            lost = 0;
  logic          exp_dpend = 1'b0, exp_cpend = 1'b0;
  logic [DW-1:0] exp_ddata = '0, exp_cdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after posedge, check at negedge, advance model at posedge.
  task automatic step(input logic rst, input logic dr, input logic [AW-1:0] da,
                      input logic cr, input logic cw, input logic [AW-1:0] ca,
                      input logic [DW-1:0] cd, input logic [SW-1:0] cs,
                      output logic obs_dg, output logic obs_cg,
                      output logic obs_crv, output logic [DW-1:0] obs_crd);
    logic cg, dg;
    logic [SW-1:0] ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    reset_i = rst; disp_req_i = dr; disp_addr_i = da;
    cpu_req_i = cr; cpu_we_i = cw; cpu_addr_i = ca; cpu_wdata_i = cd; cpu_wstrb_i = cs;
    cg  = rst && cr && (!dr || lost >= MW);
    dg  = rst && dr && !cg;
    ewe = (cg && cw) ? cs : '0;
    ea  = cg ? ca : (dg ? da : '0);
    ed  = cg ? cd : '0;
    @(negedge clk);
    check("disp_gnt",    64'(disp_gnt_o), 64'(dg));
    check("cpu_gnt",     64'(cpu_gnt_o), 64'(cg));
    check("mem_en",      64'(mem_en_o), 64'(cg || dg));
    check("mem_we",      64'(mem_we_o), 64'(ewe));
    check("mem_addr",    64'(mem_addr_o), 64'(ea));
    check("mem_wdata",   64'(mem_wdata_o), 64'(ed));
    check("disp_rvalid", 64'(disp_rvalid_o), 64'(rst && exp_dpend));
    check("cpu_rvalid",  64'(cpu_rvalid_o), 64'(rst && exp_cpend));
    check("disp_rdata",  64'(disp_rdata_o), (rst && exp_dpend) ? 64'(exp_ddata) : 64'd0);
    check("cpu_rdata",   64'(cpu_rdata_o), (rst && exp_cpend) ? 64'(exp_cdata) : 64'd0);
    obs_dg = disp_gnt_o; obs_cg = cpu_gnt_o; obs_crv = cpu_rvalid_o; obs_crd = cpu_rdata_o;
    @(posedge clk);
    if (!rst) begin
      lost = 0; exp_dpend = 1'b0; exp_cpend = 1'b0;
    end else begin
      exp_dpend = dg; exp_cpend = cg;
      if (dg) exp_ddata = ref_mem[da];
      if (cg) exp_cdata = ref_mem[ca];
      if (cg && cw)
        for (int b = 0; b < SW; b++)
          if (cs[b]) ref_mem[ca][b*8 +: 8] = cd[b*8 +: 8];
      lost = (cr && !cg) ? lost + 1 : 0;
    end
    #1;
  endtask

  task automatic idle(input logic rst);
    logic a, b, c;
    logic [DW-1:0] d;
    step(rst, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, a, b, c, d);
  endtask

  initial begin
    logic dg, cg, crv;
    logic [DW-1:0] crd;
    int waits;
    logic dp, cp, cwe;
    logic [AW-1:0] dad, cad;
    logic [DW-1:0] cdat;
    logic [SW-1:0] cst;
    logic rst;

    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = pattern(i);
    ram_init = 1'b1;
    @(posedge clk); #1;
    ram_init = 1'b0;

    // Reset held with both requests active: everything quiet
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 10'h001, 1'b1, 1'b0, 10'h002, '0, '0, dg, cg, crv, crd);
    // Release: scanout wins the first cycle
    step(1'b1, 1'b1, 10'h001, 1'b1, 1'b0, 10'h002, '0, '0, dg, cg, crv, crd);
    check("release_disp_gnt", 64'(dg), 64'd1);
    idle(1'b1); idle(1'b1);

    // Uncontended CPU read of the DEADBEEF word
    step(1'b1, 1'b0, '0, 1'b1, 1'b0, 10'h005, '0, '0, dg, cg, crv, crd);
    check("cpu_read_gnt", 64'(cg), 64'd1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, dg, cg, crv, crd);
    check("cpu_read_data", 64'(crd), 64'hDEADBEEF);
    idle(1'b1);

    // Starvation bound under continuous scanout
    waits = 0; cg = 1'b0;
    for (int i = 0; i < 20 && !cg; i++) begin
      step(1'b1, 1'b1, AW'(i), 1'b1, 1'b1, 10'h3FF, 32'h12345678, 4'hF, dg, cg, crv, crd);
      if (!cg) waits++;
    end
    check("starve_waits", 64'(waits), 64'(MW));
    step(1'b1, 1'b1, 10'h040, 1'b0, 1'b0, '0, '0, '0, dg, cg, crv, crd);
    check("starve_ack", 64'(crv), 64'd1);
    check("starve_disp_regrant", 64'(dg), 64'd1);
    idle(1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0, 10'h3FF, '0, '0, dg, cg, crv, crd);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, dg, cg, crv, crd);
    check("readback_3ff", 64'(crd), 64'h12345678);

    // Back-to-back scanout 0x000..0x00F, then drain
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b1, AW'(i), 1'b0, 1'b0, '0, '0, '0, dg, cg, crv, crd);
    idle(1'b1); idle(1'b1);

    // Request withdrawn under contention restarts the wait
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, AW'(i), 1'b1, 1'b0, 10'h007, '0, '0, dg, cg, crv, crd);
    step(1'b1, 1'b1, 10'h003, 1'b0, 1'b0, '0, '0, '0, dg, cg, crv, crd);
    waits = 0; cg = 1'b0;
    for (int i = 0; i < 20 && !cg; i++) begin
      step(1'b1, 1'b1, AW'(i + 4), 1'b1, 1'b0, 10'h007, '0, '0, dg, cg, crv, crd);
      if (!cg) waits++;
    end
    check("withdraw_waits", 64'(waits), 64'(MW));
    idle(1'b1); idle(1'b1);

    // Zero-strobe write: slot consumed, acknowledged, RAM unchanged
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 10'h020, 32'hFFFFFFFF, 4'h0, dg, cg, crv, crd);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0, 10'h020, '0, '0, dg, cg, crv, crd);
    check("zero_strb_ack", 64'(crv), 64'd1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, dg, cg, crv, crd);
    check("zero_strb_keep", 64'(crd), 64'(pattern(32)));

    // Reset mid-access drops the pending response
    step(1'b1, 1'b0, '0, 1'b1, 1'b0, 10'h010, '0, '0, dg, cg, crv, crd);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, dg, cg, crv, crd);
    check("reset_drops_rvalid", 64'(crv), 64'd0);
    idle(1'b1);
    check("reset_drops_rvalid_late", 64'(cpu_rvalid_o), 64'd0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0, 10'h011, '0, '0, dg, cg, crv, crd);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, dg, cg, crv, crd);
    check("after_reset_read", 64'(crv), 64'd1);

    // Random traffic obeying the hold-until-grant rule, with occasional resets
    dp = 1'b0; cp = 1'b0; dad = '0; cad = '0; cwe = 1'b0; cdat = '0; cst = '0;
    for (int n = 0; n < 1500; n++) begin
      if (!dp && $urandom_range(3) != 0) begin
        dp = 1'b1; dad = AW'($urandom);
      end
      if (!cp && $urandom_range(2) == 0) begin
        cp = 1'b1; cad = AW'($urandom_range(63)); cwe = 1'($urandom);
        cdat = $urandom; cst = SW'($urandom);
      end
      rst = ($urandom_range(96) != 0);
      step(rst, dp, dad, cp, cwe, cad, cdat, cst, dg, cg, crv, crd);
      if (dg) dp = 1'b0;
      if (cg) cp = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
